sync_fifo_flex: RTL and testbench
=================================

Name: sync_fifo_flex

Overview:
Parametrised single-clock FIFO, next generation of the feature-pipeline buffer between the framing, windowing and FFT stages of the MFCC core.
- Any depth ≥ 2, not only powers of two; all DEPTH entries usable.
- Standard (registered-read) and first-word-fall-through modes.
- Occupancy count, programmable almost-full/almost-empty, synchronous flush, sticky overflow/underflow flags.

Parameters:
DEPTH, 8, number of entries; integer ≥ 2, need not be a power of two
WIDTH, 8, data word width in bits
MODE, FIFO_STD, fifo_mode_e: FIFO_STD (registered read) or FIFO_FWFT (first-word-fall-through)
AF_THRESH, DEPTH-2, almost_full_o asserts when count ≥ AF_THRESH
AE_THRESH, 2, almost_empty_o asserts when count ≤ AE_THRESH

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous active-high reset
flush_i  in  1  synchronous clear of contents and flags
wr_en_i  in  1  write request
write_data_i  in  WIDTH  write data
rd_en_i  in  1  read/pop request
read_data_o  out  WIDTH  read data
read_valid_o  out  1  read_data_o holds valid popped/head data
full_o  out  1  count == DEPTH
empty_o  out  1  count == 0
almost_full_o  out  1  count ≥ AF_THRESH
almost_empty_o  out  1  count ≤ AE_THRESH
count_o  out  CW=$clog2(DEPTH+1)  current occupancy
overflow_o  out  1  sticky: write attempted while full and not accepted
underflow_o  out  1  sticky: read attempted while empty

Behaviour:
- Reset (async assert, sync release) values:
  - Pointers and count_o = 0.
  - read_data_o = 0, read_valid_o = 0, overflow_o = 0, underflow_o = 0.
  - empty_o = 1, full_o = 0, almost_empty_o = 1.
  - Storage array is not reset.
- Pointers:
  - Range 0..DEPTH-1.
  - Increment wraps DEPTH-1 → 0 by explicit compare, not bit overflow.
- Status: full/empty/almost flags are combinational from the registered count.
- Write accepted = wr_en_i && (!full_o || rd_accept). Accepted write stores data at wr_ptr and advances wr_ptr.
- Read accepted (rd_accept) = rd_en_i && !empty_o.
- Count update: +1 on write only, −1 on read only, unchanged on both.
- Full-case simultaneous events: full + wr + rd → both accepted, count stays DEPTH, no overflow.
- Empty-case simultaneous events:
  - Empty + wr + rd → write accepted, read rejected, underflow_o set, count → 1.
  - FWFT: the new word is not visible until the next cycle.
- FIFO_STD mode:
  - Accepted read registers mem[rd_ptr] into read_data_o at that edge, i.e. 1-cycle latency.
  - read_valid_o pulses high for exactly the cycle after each accepted read.
  - read_data_o holds its last value otherwise; rejected reads do not zero it.
- FIFO_FWFT mode:
  - read_data_o = mem[rd_ptr], combinational, 0 latency.
  - read_valid_o = !empty_o.
  - rd_en_i acts as pop/acknowledge of the displayed word.
- Flags:
  - overflow_o set on wr_en_i && full_o && !rd_accept.
  - underflow_o set on rd_en_i && empty_o.
  - Both are sticky until rst or flush_i.
- flush_i:
  - Has priority over wr/rd in the same cycle; that write and read are dropped.
  - Next cycle: pointers = 0, count = 0, flags = 0, read_valid_o = 0.
  - read_data_o is retained in STD mode.
- Mid-operation rst: immediate return to reset values; contents are discarded.
- Threshold check: elaboration error if AF_THRESH > DEPTH or AE_THRESH ≥ DEPTH.

Decomposition:
- Package fifo_pkg:
  - fifo_mode_e enum {FIFO_STD, FIFO_FWFT}.
  - fifo_cnt_w(depth) function returning $clog2(depth+1).
  - Default threshold constants.
- Sub-module fifo_wrap_ptr:
  - Parameter DEPTH.
  - Ports clk, rst, clr_i, inc_i, ptr_o.
  - Modulo-DEPTH pointer; instantiated twice (write and read).

Test Plan:
- DEPTH=6, STD: write 0x11..0x16 → full_o=1 after 6th write, count_o=6. 7th write dropped, overflow_o=1. Reading 6 → 0x11..0x16 each one cycle after rd_en_i, read_valid_o pulses, then empty_o=1.
- DEPTH=6, wrap: write 4, read 4, write 6, read 6 → order preserved across pointer wrap 5→0, count_o never exceeds 6.
- Full with simultaneous wr (0xAA) + rd → count_o stays 6, overflow_o stays 0, 0xAA read last.
- Empty with rd_en_i and wr_en_i (0x5C) → underflow_o=1, count_o=1. FWFT: read_data_o=0x5C, read_valid_o=1 next cycle.
- AF_THRESH=4, AE_THRESH=1: count 1 → almost_empty_o=1; count 2 → 0; count 4 → almost_full_o=1; count 3 → 0.
- flush_i with count=3 and overflow_o=1, plus wr_en_i same cycle → next cycle count_o=0, empty_o=1, overflow_o=0, write dropped. Async rst pulsed mid-burst clears all outputs without a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types, widths and default thresholds for the flexible FIFO
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int DEFAULT_DEPTH     = 8;
    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_AF_MARGIN = 2;
    localparam int DEFAULT_AE_THRESH = 2;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// rtl/fifo_wrap_ptr.sv - modulo-DEPTH pointer with synchronous clear
module fifo_wrap_ptr #(
    parameter int DEPTH = 8,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);

    // Explicit wrap compare so non-power-of-two depths use every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_o <= '0;
        end else if (clr_i) begin
            ptr_o <= '0;
        end else if (inc_i) begin
            ptr_o <= (ptr_o == PW'(DEPTH - 1)) ? '0 : ptr_o + 1'b1;
        end
    end

endmodule

// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - single-clock FIFO, any depth, registered-read or FWFT output
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter int         DEPTH     = DEFAULT_DEPTH,
    parameter int         WIDTH     = DEFAULT_WIDTH,
    parameter fifo_mode_e MODE      = FIFO_STD,
    parameter int         AF_THRESH = DEPTH - DEFAULT_AF_MARGIN,
    parameter int         AE_THRESH = DEFAULT_AE_THRESH,
    localparam int        CW        = fifo_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] write_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] read_data_o,
    output logic             read_valid_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic [CW-1:0]    count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int PW = $clog2(DEPTH);

    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_flex: DEPTH must be at least 2");
    end
    if (AF_THRESH > DEPTH || AE_THRESH >= DEPTH) begin : g_bad_thresh
        $error("sync_fifo_flex: AF_THRESH must be <= DEPTH and AE_THRESH < DEPTH");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             rd_acc;
    logic             wr_acc;
    logic             do_wr;
    logic             do_rd;

    assign full_o         = (count == CW'(DEPTH));
    assign empty_o        = (count == '0);
    assign almost_full_o  = (count >= CW'(AF_THRESH));
    assign almost_empty_o = (count <= CW'(AE_THRESH));
    assign count_o        = count;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
    assign rd_acc = rd_en_i && !empty_o;
    assign wr_acc = wr_en_i && (!full_o || rd_acc);
    assign do_wr  = wr_acc && !flush_i;
    assign do_rd  = rd_acc && !flush_i;

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush_i),
        .inc_i (do_wr),
        .ptr_o (wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush_i),
        .inc_i (do_rd),
        .ptr_o (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= write_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush_i) begin
            count <= '0;
        end else if (do_wr && !do_rd) begin
            count <= count + CW'(1);
        end else if (do_rd && !do_wr) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (flush_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (wr_en_i && full_o && !rd_acc) begin
                overflow_o <= 1'b1;
            end
            if (rd_en_i && empty_o) begin
                underflow_o <= 1'b1;
            end
        end
    end

    if (MODE == FIFO_FWFT) begin : g_fwft
        assign read_data_o  = mem[rd_ptr];
        assign read_valid_o = !empty_o;
    end else begin : g_std
        logic [WIDTH-1:0] data_q;
        logic             valid_q;

        // Flush drops the valid pulse but keeps the last word on the bus.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (flush_i) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_acc;
                if (rd_acc) begin
                    data_q <= mem[rd_ptr];
                end
            end
        end

        assign read_data_o  = data_q;
        assign read_valid_o = valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb/tb_sync_fifo_flex.sv - STD and FWFT instances driven in lockstep against a queue model
module tb_sync_fifo_flex;
    import fifo_pkg::*;

    localparam int D = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [7:0] s_rdata, f_rdata;
    logic       s_rvalid, f_rvalid, s_full, f_full, s_empty, f_empty;
    logic       s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_unf, f_unf;
    logic [2:0] s_count, f_count;

    always #5 clk = ~clk;

    sync_fifo_flex #(.DEPTH(D), .WIDTH(8), .MODE(FIFO_STD), .AF_THRESH(4), .AE_THRESH(1)) u_std (
        .clk(clk), .rst(rst), .flush_i(flush), .wr_en_i(wr_en), .write_data_i(wdata),
        .rd_en_i(rd_en), .read_data_o(s_rdata), .read_valid_o(s_rvalid), .full_o(s_full),
        .empty_o(s_empty), .almost_full_o(s_af), .almost_empty_o(s_ae), .count_o(s_count),
        .overflow_o(s_ovf), .underflow_o(s_unf)
    );

    sync_fifo_flex #(.DEPTH(D), .WIDTH(8), .MODE(FIFO_FWFT), .AF_THRESH(4), .AE_THRESH(1)) u_fwft (
        .clk(clk), .rst(rst), .flush_i(flush), .wr_en_i(wr_en), .write_data_i(wdata),
        .rd_en_i(rd_en), .read_data_o(f_rdata), .read_valid_o(f_rvalid), .full_o(f_full),
        .empty_o(f_empty), .almost_full_o(f_af), .almost_empty_o(f_ae), .count_o(f_count),
        .overflow_o(f_ovf), .underflow_o(f_unf)
    );

    logic [7:0] q[$];
    logic       m_ovf, m_unf, m_valid;
    logic [7:0] m_data;
    int         n_vec = 0;
    int         n_fail = 0;
    logic       chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_valid = 1'b0;
        m_data = 8'h00;
    endtask

    task automatic model_step(input logic w, input logic r, input logic f, input logic [7:0] d);
        bit racc, wacc;
        if (f) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_valid = 1'b0;
            return;
        end
        racc = r && (q.size() != 0);
        wacc = w && ((q.size() != D) || racc);
        if (w && q.size() == D && !racc) m_ovf = 1'b1;
        if (r && q.size() == 0) m_unf = 1'b1;
        m_valid = racc;
        if (racc) m_data = q.pop_front();
        if (wacc) q.push_back(d);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int n;
            n = q.size();
            chk("std.count", int'(s_count), n);
            chk("fwft.count", int'(f_count), n);
            chk("std.empty", int'(s_empty), int'(n == 0));
            chk("fwft.empty", int'(f_empty), int'(n == 0));
            chk("std.full", int'(s_full), int'(n == D));
            chk("fwft.full", int'(f_full), int'(n == D));
            chk("std.af", int'(s_af), int'(n >= 4));
            chk("fwft.af", int'(f_af), int'(n >= 4));
            chk("std.ae", int'(s_ae), int'(n <= 1));
            chk("fwft.ae", int'(f_ae), int'(n <= 1));
            chk("std.ovf", int'(s_ovf), int'(m_ovf));
            chk("fwft.ovf", int'(f_ovf), int'(m_ovf));
            chk("std.unf", int'(s_unf), int'(m_unf));
            chk("fwft.unf", int'(f_unf), int'(m_unf));
            chk("std.rvalid", int'(s_rvalid), int'(m_valid));
            chk("std.rdata", int'(s_rdata), int'(m_data));
            chk("fwft.rvalid", int'(f_rvalid), int'(n != 0));
            if (n != 0) chk("fwft.rdata", int'(f_rdata), int'(q[0]));
        end
    end

    task automatic cyc(input logic w, input logic r, input logic f, input logic [7:0] d);
        wr_en = w;
        rd_en = r;
        flush = f;
        wdata = d;
        @(posedge clk);
        model_step(w, r, f, d);
        @(negedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst.count", int'(s_count), 0);
        chk("rst.empty", int'(s_empty), 1);
        chk("rst.full", int'(s_full), 0);
        chk("rst.ae", int'(s_ae), 1);
        chk("rst.rdata", int'(s_rdata), 0);
        chk("rst.rvalid", int'(s_rvalid), 0);
        chk("rst.fwft_rvalid", int'(f_rvalid), 0);

        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 8'h11 + 8'(i));
        chk("fill.count", int'(s_count), 6);
        chk("fill.full", int'(s_full), 1);
        chk("fill.fwft_head", int'(f_rdata), 8'h11);
        cyc(1, 0, 0, 8'h77);
        chk("fill.ovf", int'(s_ovf), 1);
        cyc(0, 1, 0, 8'h00);
        chk("drain.first", int'(s_rdata), 8'h11);
        chk("drain.pulse", int'(s_rvalid), 1);
        for (int i = 1; i < 6; i++) cyc(0, 1, 0, 8'h00);
        chk("drain.last", int'(s_rdata), 8'h16);
        chk("drain.empty", int'(s_empty), 1);
        cyc(0, 0, 0, 8'h00);
        chk("drain.pulse_end", int'(s_rvalid), 0);
        chk("drain.hold", int'(s_rdata), 8'h16);

        cyc(0, 0, 1, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'h20 + 8'(i));
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'h00);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 8'h30 + 8'(i));
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 8'h00);
        chk("wrap.last", int'(s_rdata), 8'h35);

        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 8'h40 + 8'(i));
        cyc(1, 1, 0, 8'hAA);
        chk("fullrw.count", int'(s_count), 6);
        chk("fullrw.ovf", int'(s_ovf), 0);
        chk("fullrw.pop", int'(s_rdata), 8'h40);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 8'h00);
        chk("fullrw.aa_last", int'(s_rdata), 8'hAA);

        cyc(1, 1, 0, 8'h5C);
        chk("emptyrw.unf", int'(s_unf), 1);
        chk("emptyrw.count", int'(s_count), 1);
        chk("emptyrw.fwft_data", int'(f_rdata), 8'h5C);
        chk("emptyrw.fwft_valid", int'(f_rvalid), 1);
        chk("emptyrw.std_valid", int'(s_rvalid), 0);
        chk("thr.ae_at1", int'(s_ae), 1);
        cyc(1, 0, 0, 8'h61);
        chk("thr.ae_at2", int'(s_ae), 0);
        cyc(1, 0, 0, 8'h62);
        cyc(1, 0, 0, 8'h63);
        chk("thr.af_at4", int'(s_af), 1);
        cyc(0, 1, 0, 8'h00);
        chk("thr.af_at3", int'(s_af), 0);

        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'h70 + 8'(i));
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'h00);
        chk("flush.pre_count", int'(s_count), 3);
        chk("flush.pre_ovf", int'(s_ovf), 1);
        cyc(1, 0, 1, 8'hEE);
        chk("flush.count", int'(s_count), 0);
        chk("flush.empty", int'(s_empty), 1);
        chk("flush.ovf", int'(s_ovf), 0);
        chk("flush.unf", int'(s_unf), 0);

        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 8'h90 + 8'(i));
        wr_en = 1'b1;
        rd_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst.count", int'(s_count), 0);
        chk("arst.empty", int'(s_empty), 1);
        chk("arst.rdata", int'(s_rdata), 0);
        chk("arst.rvalid", int'(s_rvalid), 0);
        chk("arst.fwft_rvalid", int'(f_rvalid), 0);
        chk("arst.unf", int'(s_unf), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;

        for (int i = 0; i < 3000; i++) begin
            int phase;
            phase = (i / 200) % 3;
            cyc(($urandom_range(0, 99) < (phase == 0 ? 75 : phase == 1 ? 25 : 50)),
                ($urandom_range(0, 99) < (phase == 1 ? 75 : phase == 0 ? 25 : 50)),
                ($urandom_range(0, 63) == 0),
                8'($urandom));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
